// File: rtl/ipa_dma_pkg.sv
// rtl/ipa_dma_pkg.sv - shared types and field layout helpers for the IPA context loader
package ipa_dma_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_HDR   = 3'd1,
      S_INST  = 3'd2,
      S_CONST = 3'd3,
      S_DONE  = 3'd4,
      S_EXEC  = 3'd5
   } state_e;

   // Header layout, LSB first: last, tile id, instruction count, constant count
   localparam int HDR_LAST_BIT = 0;
   localparam int HDR_TILE_LSB = 1;

   function automatic int hdr_ni_lsb(input int tile_w);
      return 1 + tile_w;
   endfunction

   function automatic int hdr_nc_lsb(input int tile_w, input int inst_w);
      return 1 + tile_w + inst_w;
   endfunction

   function automatic int hdr_width(input int tile_w, input int inst_w, input int const_w);
      return 1 + tile_w + inst_w + const_w;
   endfunction

   function automatic int idx_width(input int inst_w, input int const_w);
      return (inst_w > const_w) ? inst_w : const_w;
   endfunction

   // Out_Addr layout: {word index, const flag, one-hot tile mask}
   function automatic int oaddr_const_bit(input int nb_tiles);
      return nb_tiles;
   endfunction

   function automatic int oaddr_idx_lsb(input int nb_tiles);
      return nb_tiles + 1;
   endfunction

   function automatic int oaddr_width(input int nb_tiles, input int idx_w);
      return nb_tiles + 1 + idx_w;
   endfunction

endpackage

// File: rtl/ipa_ctx_loader_if.sv
// rtl/ipa_ctx_loader_if.sv - GCM read / context-write / control bus of the context loader
interface ipa_ctx_if #(
   parameter int GCM_ADDR_WIDTH = 9,
   parameter int DATA_WIDTH     = 64,
   parameter int OADDR_W        = 24
);
   logic                      Context_Fetch_En;
   logic [4:0]                s_ipa_cfg_id;
   logic                      read_valid;
   logic [DATA_WIDTH-1:0]     In_Data;
   logic                      exec_comp;
   logic [GCM_ADDR_WIDTH-1:0] Context_Addr;
   logic                      ipa_gcm_req_o;
   logic                      Write_En;
   logic [DATA_WIDTH-1:0]     Out_Data;
   logic [OADDR_W-1:0]        Out_Addr;
   logic                      Exec_En_Out;
   logic                      busy_o;
   logic [4:0]                s_ipa_cfg_r_id;
   logic                      error_o;

   modport master (
      input  Context_Fetch_En, s_ipa_cfg_id, read_valid, In_Data, exec_comp,
      output Context_Addr, ipa_gcm_req_o, Write_En, Out_Data, Out_Addr,
             Exec_En_Out, busy_o, s_ipa_cfg_r_id, error_o
   );

   modport slave (
      output Context_Fetch_En, s_ipa_cfg_id, read_valid, In_Data, exec_comp,
      input  Context_Addr, ipa_gcm_req_o, Write_En, Out_Data, Out_Addr,
             Exec_En_Out, busy_o, s_ipa_cfg_r_id, error_o
   );
endinterface

// File: rtl/ipa_ctx_hdr_decode.sv
// rtl/ipa_ctx_hdr_decode.sv - splits a tile header word into counts, last flag and tile mask
module ipa_ctx_hdr_decode
   import ipa_dma_pkg::*;
#(
   parameter int NB_TILES    = 16,
   parameter int TILE_W      = 4,
   parameter int INST_CNT_W  = 7,
   parameter int CONST_CNT_W = 5
) (
   input  logic [hdr_width(TILE_W, INST_CNT_W, CONST_CNT_W)-1:0] hdr,
   output logic [INST_CNT_W-1:0]                                 ni,
   output logic [CONST_CNT_W-1:0]                                nc,
   output logic                                                  last,
   output logic [NB_TILES-1:0]                                   mask,
   output logic                                                  bad
);
   localparam int               NI_LSB     = hdr_ni_lsb(TILE_W);
   localparam int               NC_LSB     = hdr_nc_lsb(TILE_W, INST_CNT_W);
   localparam logic [TILE_W:0]  TILE_LIMIT = (TILE_W+1)'(NB_TILES);

   logic [TILE_W-1:0] tile;

   assign last = hdr[HDR_LAST_BIT];
   assign tile = hdr[HDR_TILE_LSB +: TILE_W];
   assign ni   = hdr[NI_LSB +: INST_CNT_W];
   assign nc   = hdr[NC_LSB +: CONST_CNT_W];

   // Out-of-range tiles (non power-of-two arrays) select no tile at all
   assign bad  = ({1'b0, tile} >= TILE_LIMIT);
   assign mask = bad ? '0 : (NB_TILES'(1) << tile);
endmodule

// File: rtl/ipa_ctx_loader.sv
// rtl/ipa_ctx_loader.sv - header-driven context DMA from GCM into the PE array, then execution launch
module ipa_ctx_loader
   import ipa_dma_pkg::*;
#(
   parameter int NB_ROWS        = 4,
   parameter int NB_COLS        = 4,
   parameter int GCM_ADDR_WIDTH = 9,
   parameter int DATA_WIDTH     = 64,
   parameter int INST_CNT_W     = 7,
   parameter int CONST_CNT_W    = 5
) (
   input logic       Clk,
   input logic       Reset,
   ipa_ctx_if.master bus
);
   localparam int NB_TILES = NB_ROWS * NB_COLS;
   localparam int TILE_W   = $clog2(NB_TILES);
   localparam int IDX_W    = idx_width(INST_CNT_W, CONST_CNT_W);
   localparam int HDR_W    = hdr_width(TILE_W, INST_CNT_W, CONST_CNT_W);
   localparam int OADDR_W  = oaddr_width(NB_TILES, IDX_W);

   state_e state, state_nxt;

   logic [GCM_ADDR_WIDTH-1:0] ctx_addr;
   logic [4:0]                cfg_id;
   logic                      err;
   logic [INST_CNT_W-1:0]     ni_q;
   logic [CONST_CNT_W-1:0]    nc_q;
   logic                      last_q;
   logic [NB_TILES-1:0]       mask_q;
   logic                      bad_q;
   logic [IDX_W-1:0]          idx;
   logic                      we_q;
   logic [DATA_WIDTH-1:0]     odata_q;
   logic [OADDR_W-1:0]        oaddr_q;

   logic [INST_CNT_W-1:0]     hd_ni;
   logic [CONST_CNT_W-1:0]    hd_nc;
   logic                      hd_last;
   logic [NB_TILES-1:0]       hd_mask;
   logic                      hd_bad;

   logic gcm_req, exec_en, busy;
   logic [4:0] r_id;
   logic hdr_acc, word_acc, is_const, inst_end, const_end, word_end;
   state_e tile_nxt;

   ipa_ctx_hdr_decode #(
      .NB_TILES   (NB_TILES),
      .TILE_W     (TILE_W),
      .INST_CNT_W (INST_CNT_W),
      .CONST_CNT_W(CONST_CNT_W)
   ) u_hdr_decode (
      .hdr (bus.In_Data[HDR_W-1:0]),
      .ni  (hd_ni),
      .nc  (hd_nc),
      .last(hd_last),
      .mask(hd_mask),
      .bad (hd_bad)
   );

   assign is_const  = (state == S_CONST);
   assign hdr_acc   = (state == S_HDR) && bus.read_valid;
   assign word_acc  = ((state == S_INST) || is_const) && bus.read_valid;
   assign inst_end  = (idx == IDX_W'(ni_q) - IDX_W'(1));
   assign const_end = (idx == IDX_W'(nc_q) - IDX_W'(1));
   assign word_end  = is_const ? const_end : inst_end;
   assign tile_nxt  = last_q ? S_DONE : S_HDR;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (bus.Context_Fetch_En) state_nxt = S_HDR;
         S_HDR:
            if (bus.read_valid) begin
               if (hd_ni != '0)      state_nxt = S_INST;
               else if (hd_nc != '0) state_nxt = S_CONST;
               else if (hd_last)     state_nxt = S_DONE;
            end
         S_INST:
            if (bus.read_valid && inst_end)
               state_nxt = (nc_q != '0) ? S_CONST : tile_nxt;
         S_CONST: if (bus.read_valid && const_end) state_nxt = tile_nxt;
         S_DONE:  state_nxt = S_EXEC;
         S_EXEC:  if (bus.exec_comp) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      gcm_req = 1'b0;
      exec_en = 1'b0;
      busy    = 1'b1;
      r_id    = '0;
      case (state)
         S_IDLE:                  busy    = 1'b0;
         S_HDR, S_INST, S_CONST:  gcm_req = 1'b1;
         S_DONE:                  exec_en = 1'b1;
         S_EXEC:                  if (bus.exec_comp) r_id = cfg_id;
         default:                 busy    = 1'b0;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         ctx_addr <= '0;
         cfg_id   <= '0;
         err      <= 1'b0;
         ni_q     <= '0;
         nc_q     <= '0;
         last_q   <= 1'b0;
         mask_q   <= '0;
         bad_q    <= 1'b0;
         idx      <= '0;
         we_q     <= 1'b0;
         odata_q  <= '0;
         oaddr_q  <= '0;
      end else begin
         we_q    <= 1'b0;
         odata_q <= '0;
         oaddr_q <= '0;
         if ((state == S_IDLE) && bus.Context_Fetch_En) begin
            ctx_addr <= '0;
            cfg_id   <= bus.s_ipa_cfg_id;
            err      <= 1'b0;
         end
         if (hdr_acc) begin
            ctx_addr <= ctx_addr + GCM_ADDR_WIDTH'(1);
            ni_q     <= hd_ni;
            nc_q     <= hd_nc;
            last_q   <= hd_last;
            mask_q   <= hd_mask;
            bad_q    <= hd_bad;
            idx      <= '0;
            if (hd_bad) err <= 1'b1;
         end
         // Bad tiles still drain their words so the GCM walk stays aligned
         if (word_acc) begin
            ctx_addr <= ctx_addr + GCM_ADDR_WIDTH'(1);
            we_q     <= !bad_q;
            if (!bad_q) begin
               odata_q <= bus.In_Data;
               oaddr_q <= {idx, is_const, mask_q};
            end
            idx <= word_end ? '0 : idx + IDX_W'(1);
         end
      end
   end

   assign bus.Context_Addr   = ctx_addr;
   assign bus.ipa_gcm_req_o  = gcm_req;
   assign bus.Write_En       = we_q;
   assign bus.Out_Data       = odata_q;
   assign bus.Out_Addr       = oaddr_q;
   assign bus.Exec_En_Out    = exec_en;
   assign bus.busy_o         = busy;
   assign bus.s_ipa_cfg_r_id = r_id;
   assign bus.error_o        = err;
endmodule

// File: tb/tb_ipa_ctx_loader.sv
// tb/tb_ipa_ctx_loader.sv - bench for ipa_ctx_loader (default 4x4 plus a 2x3 array for bad tile ids)
module tb_ipa_ctx_loader;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_pass = 0;
   int   wr_cnt = 0;
   int   b1_wr = 0;

   always #5 clk = ~clk;

   ipa_ctx_if #(.GCM_ADDR_WIDTH(9), .DATA_WIDTH(64), .OADDR_W(24)) b0 ();
   ipa_ctx_if #(.GCM_ADDR_WIDTH(9), .DATA_WIDTH(64), .OADDR_W(14)) b1 ();

   ipa_ctx_loader #(
      .NB_ROWS(4), .NB_COLS(4), .GCM_ADDR_WIDTH(9), .DATA_WIDTH(64),
      .INST_CNT_W(7), .CONST_CNT_W(5)
   ) u_dut0 (
      .Clk(clk), .Reset(rst_n), .bus(b0.master)
   );

   ipa_ctx_loader #(
      .NB_ROWS(2), .NB_COLS(3), .GCM_ADDR_WIDTH(9), .DATA_WIDTH(64),
      .INST_CNT_W(7), .CONST_CNT_W(5)
   ) u_dut1 (
      .Clk(clk), .Reset(rst_n), .bus(b1.master)
   );

   typedef struct {
      logic [63:0] data;
      bit          wr;
      logic [23:0] oaddr;
   } word_t;

   typedef struct {
      logic [63:0] data;
      logic [23:0] oaddr;
   } exp_t;

   typedef struct {
      bit       last;
      int       tile;
      int       ni;
      int       nc;
      logic [4:0] id;
      int       exp_addr;
      int       exp_nwr;
   } vec_t;

   word_t img[$];
   exp_t  sb[$];
   exp_t  mon_e;
   vec_t  vecs[4];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   always @(negedge clk) begin
      if (b0.Write_En) begin
         wr_cnt++;
         chk("write_has_expected_entry", sb.size() != 0, 1);
         if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            chk("wr_out_addr", b0.Out_Addr, mon_e.oaddr);
            chk("wr_out_data", b0.Out_Data, mon_e.data);
         end
      end
      if (b1.Write_En) b1_wr++;
   end

   function automatic logic [63:0] hdr0(input bit last, input int tile, input int ni, input int nc);
      logic [63:0] h;
      h        = '0;
      h[0]     = last;
      h[4:1]   = tile[3:0];
      h[11:5]  = ni[6:0];
      h[16:12] = nc[4:0];
      return h;
   endfunction

   function automatic logic [63:0] hdr1(input bit last, input int tile, input int ni, input int nc);
      logic [63:0] h;
      h        = '0;
      h[0]     = last;
      h[3:1]   = tile[2:0];
      h[10:4]  = ni[6:0];
      h[15:11] = nc[4:0];
      return h;
   endfunction

   function automatic logic [23:0] mk_oaddr(input int tile, input bit c, input int i);
      logic [23:0] a;
      a        = '0;
      a[tile]  = 1'b1;
      a[16]    = c;
      a[23:17] = i[6:0];
      return a;
   endfunction

   task automatic add_tile(input bit last, input int tile, input int ni, input int nc);
      word_t w;
      w = '{data: hdr0(last, tile, ni, nc), wr: 1'b0, oaddr: '0};
      img.push_back(w);
      for (int i = 0; i < ni; i++) begin
         w = '{data: {$urandom, $urandom}, wr: 1'b1, oaddr: mk_oaddr(tile, 1'b0, i)};
         img.push_back(w);
      end
      for (int i = 0; i < nc; i++) begin
         w = '{data: {$urandom, $urandom}, wr: 1'b1, oaddr: mk_oaddr(tile, 1'b1, i)};
         img.push_back(w);
      end
   endtask

   task automatic start0(input logic [4:0] id);
      @(posedge clk); #1;
      b0.s_ipa_cfg_id     = id;
      b0.Context_Fetch_En = 1'b1;
      @(posedge clk); #1;
      b0.Context_Fetch_En = 1'b0;
      b0.s_ipa_cfg_id     = '0;
      chk("start_req", b0.ipa_gcm_req_o, 1);
      chk("start_addr", b0.Context_Addr, 0);
      chk("start_busy", b0.busy_o, 1);
   endtask

   task automatic feed_range(input int lo, input int hi, input bit toggle);
      for (int k = lo; k < hi; k++) begin
         if (toggle && k > lo) begin
            b0.read_valid = 1'b0;
            b0.In_Data    = '0;
            @(posedge clk); #1;
         end
         b0.read_valid = 1'b1;
         b0.In_Data    = img[k].data;
         if (img[k].wr) sb.push_back('{data: img[k].data, oaddr: img[k].oaddr});
         @(posedge clk); #1;
      end
      b0.read_valid = 1'b0;
      b0.In_Data    = '0;
   endtask

   task automatic finish_exec(input logic [4:0] id, input int exp_addr);
      chk("exec_pulse", b0.Exec_En_Out, 1);
      chk("req_dropped", b0.ipa_gcm_req_o, 0);
      chk("ctx_addr_end", b0.Context_Addr, exp_addr);
      chk("no_error", b0.error_o, 0);
      @(posedge clk); #1;
      chk("exec_one_cycle", b0.Exec_En_Out, 0);
      chk("busy_in_exec", b0.busy_o, 1);
      chk("all_writes_seen", sb.size(), 0);
      b0.exec_comp = 1'b1;
      #1;
      chk("r_id_on_comp", b0.s_ipa_cfg_r_id, id);
      @(posedge clk); #1;
      b0.exec_comp = 1'b0;
      chk("busy_cleared", b0.busy_o, 0);
      chk("r_id_idle", b0.s_ipa_cfg_r_id, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      int w0;
      vecs[0] = '{last: 1, tile: 3,  ni: 2, nc: 1, id: 5'h0A, exp_addr: 4, exp_nwr: 3};
      vecs[1] = '{last: 1, tile: 0,  ni: 0, nc: 0, id: 5'h11, exp_addr: 1, exp_nwr: 0};
      vecs[2] = '{last: 1, tile: 15, ni: 0, nc: 3, id: 5'h1F, exp_addr: 4, exp_nwr: 3};
      vecs[3] = '{last: 1, tile: 9,  ni: 4, nc: 2, id: 5'h03, exp_addr: 7, exp_nwr: 6};

      b0.Context_Fetch_En = 1'b0; b0.s_ipa_cfg_id = '0; b0.read_valid = 1'b0;
      b0.In_Data = '0; b0.exec_comp = 1'b0;
      b1.Context_Fetch_En = 1'b0; b1.s_ipa_cfg_id = '0; b1.read_valid = 1'b0;
      b1.In_Data = '0; b1.exec_comp = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_ctx_addr", b0.Context_Addr, 0);
      chk("rst_req", b0.ipa_gcm_req_o, 0);
      chk("rst_we", b0.Write_En, 0);
      chk("rst_busy", b0.busy_o, 0);
      chk("rst_exec", b0.Exec_En_Out, 0);
      chk("rst_error", b0.error_o, 0);
      chk("rst_b1_busy", b1.busy_o, 0);
      rst_n = 1'b1;

      // Table-driven single-tile loads with read_valid held high
      foreach (vecs[v]) begin
         img.delete();
         add_tile(vecs[v].last, vecs[v].tile, vecs[v].ni, vecs[v].nc);
         w0 = wr_cnt;
         start0(vecs[v].id);
         feed_range(0, img.size(), 1'b0);
         finish_exec(vecs[v].id, vecs[v].exp_addr);
         chk("write_count", wr_cnt - w0, vecs[v].exp_nwr);
      end

      // Two tiles with read_valid toggling
      img.delete();
      add_tile(1'b0, 0, 1, 0);
      add_tile(1'b1, 15, 0, 2);
      w0 = wr_cnt;
      start0(5'h07);
      feed_range(0, img.size(), 1'b1);
      finish_exec(5'h07, 5);
      chk("two_tile_writes", wr_cnt - w0, 3);

      // exec_comp during INST and a start during EXEC are both ignored
      img.delete();
      add_tile(1'b1, 2, 3, 0);
      start0(5'h15);
      feed_range(0, 2, 1'b0);
      b0.exec_comp = 1'b1;
      @(posedge clk); #1;
      b0.exec_comp = 1'b0;
      chk("ign_comp_busy", b0.busy_o, 1);
      chk("ign_comp_req", b0.ipa_gcm_req_o, 1);
      chk("ign_comp_addr", b0.Context_Addr, 2);
      feed_range(2, 4, 1'b0);
      chk("ign_exec_pulse", b0.Exec_En_Out, 1);
      @(posedge clk); #1;
      b0.s_ipa_cfg_id     = 5'h09;
      b0.Context_Fetch_En = 1'b1;
      @(posedge clk); #1;
      b0.Context_Fetch_En = 1'b0;
      b0.s_ipa_cfg_id     = '0;
      chk("ign_start_busy", b0.busy_o, 1);
      chk("ign_start_req", b0.ipa_gcm_req_o, 0);
      chk("ign_start_addr", b0.Context_Addr, 4);
      b0.exec_comp = 1'b1;
      #1;
      chk("ign_r_id", b0.s_ipa_cfg_r_id, 5'h15);
      @(posedge clk); #1;
      b0.exec_comp = 1'b0;
      chk("ign_busy_done", b0.busy_o, 0);
      chk("ign_sb_empty", sb.size(), 0);

      // Reset asserted mid-INST, then a clean restart
      img.delete();
      add_tile(1'b1, 4, 3, 1);
      start0(5'h0C);
      feed_range(0, 1, 1'b0);
      b0.read_valid = 1'b1;
      b0.In_Data    = img[1].data;
      @(posedge clk); #1;
      rst_n = 1'b0;
      b0.read_valid = 1'b0;
      b0.In_Data    = '0;
      #1;
      chk("mid_rst_we", b0.Write_En, 0);
      chk("mid_rst_data", b0.Out_Data, 0);
      chk("mid_rst_oaddr", b0.Out_Addr, 0);
      chk("mid_rst_ctx_addr", b0.Context_Addr, 0);
      chk("mid_rst_req", b0.ipa_gcm_req_o, 0);
      chk("mid_rst_busy", b0.busy_o, 0);
      chk("mid_rst_exec", b0.Exec_En_Out, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      img.delete();
      add_tile(1'b1, 4, 3, 1);
      w0 = wr_cnt;
      start0(5'h0C);
      feed_range(0, img.size(), 1'b0);
      finish_exec(5'h0C, 5);
      chk("restart_writes", wr_cnt - w0, 4);

      // 2x3 array: tile 7 is out of range
      @(posedge clk); #1;
      b1.s_ipa_cfg_id     = 5'h1A;
      b1.Context_Fetch_En = 1'b1;
      @(posedge clk); #1;
      b1.Context_Fetch_En = 1'b0;
      b1.s_ipa_cfg_id     = '0;
      b1.read_valid       = 1'b1;
      b1.In_Data          = hdr1(1'b1, 7, 1, 0);
      @(posedge clk); #1;
      chk("bad_error_set", b1.error_o, 1);
      b1.In_Data = 64'hDEAD_BEEF_0123_4567;
      @(posedge clk); #1;
      b1.read_valid = 1'b0;
      b1.In_Data    = '0;
      chk("bad_no_we", b1.Write_En, 0);
      chk("bad_ctx_addr", b1.Context_Addr, 2);
      chk("bad_exec_pulse", b1.Exec_En_Out, 1);
      @(posedge clk); #1;
      b1.exec_comp = 1'b1;
      #1;
      chk("bad_r_id", b1.s_ipa_cfg_r_id, 5'h1A);
      @(posedge clk); #1;
      b1.exec_comp = 1'b0;
      chk("bad_busy_done", b1.busy_o, 0);
      chk("bad_error_sticky", b1.error_o, 1);
      chk("bad_write_count", b1_wr, 0);
      b1.Context_Fetch_En = 1'b1;
      @(posedge clk); #1;
      b1.Context_Fetch_En = 1'b0;
      chk("bad_error_cleared", b1.error_o, 0);
      chk("bad_restart_req", b1.ipa_gcm_req_o, 1);

      @(posedge clk); #1;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
